// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep checker.
// Table bit ordering: row r lives at bit (ROWS-1-r), so row 0 is the MSB.
package tt_sweep_pkg;

  localparam int ROWS  = 16;
  localparam int ROW_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_STORE,
    ST_DONE
  } state_e;

  function automatic logic [ROW_W-1:0] tt_bit_idx(input logic [ROW_W-1:0] row);
    return ROW_W'(ROWS - 1) - row;
  endfunction

endpackage

// File: rtl/tt_majority_sampler.sv
// Counts ones over SAMPLES consecutive enabled clocks and reports the majority vote.
// The vote is meaningful once valid is high.
module tt_majority_sampler #(
  parameter int SAMPLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  input  logic din,
  output logic last,
  output logic valid,
  output logic vote
);

  logic [3:0] ones_q, ones_d;
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    ones_d = ones_q;
    cnt_d  = cnt_q;
    if (clear) begin
      ones_d = '0;
      cnt_d  = '0;
    end else if (en) begin
      ones_d = ones_q + {3'd0, din};
      cnt_d  = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= '0;
      cnt_q  <= '0;
    end else begin
      ones_q <= ones_d;
      cnt_q  <= cnt_d;
    end
  end

  assign last  = en && (cnt_q == 4'(SAMPLES - 1));
  assign valid = (cnt_q == 4'(SAMPLES));
  // SAMPLES is odd, so a strict majority always exists.
  assign vote  = (ones_q > 4'(SAMPLES / 2));

endmodule

// File: rtl/tt_sweep_checker.sv
// Drives all 16 input rows into a 4-input netlist, majority-samples its output,
// and compares the captured truth table against EXPECTED.
module tt_sweep_checker
  import tt_sweep_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 4,
  parameter int          SAMPLES       = 3,
  parameter logic [15:0] EXPECTED      = 16'h5215
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        dut_out,
  output logic        in1,
  output logic        in2,
  output logic        in3,
  output logic        in4,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic        match,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_bad_row
);

  localparam int SW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  // With no settle time a new row goes straight to sampling.
  localparam state_e ROW_ENTRY = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [SW-1:0]      settle_q, settle_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [15:0]        tt_q, tt_d;
  logic               match_q, match_d;
  logic [4:0]         mcnt_q, mcnt_d;
  logic [3:0]         first_q, first_d;

  logic               smp_clear, smp_en, smp_last, smp_valid, smp_vote;
  logic [ROW_W-1:0]   bit_idx;

  tt_majority_sampler #(.SAMPLES(SAMPLES)) u_sampler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (smp_clear),
    .en    (smp_en),
    .din   (dut_out),
    .last  (smp_last),
    .valid (smp_valid),
    .vote  (smp_vote)
  );

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    settle_d  = settle_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tt_d      = tt_q;
    match_d   = match_q;
    mcnt_d    = mcnt_q;
    first_d   = first_q;
    smp_clear = 1'b0;
    smp_en    = 1'b0;
    bit_idx   = tt_bit_idx(row_q);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ROW_ENTRY;
          row_d     = '0;
          settle_d  = '0;
          busy_d    = 1'b1;
          tt_d      = '0;
          match_d   = 1'b0;
          mcnt_d    = '0;
          first_d   = '0;
          smp_clear = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = ST_SAMPLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        smp_en = 1'b1;
        if (smp_last) state_d = ST_STORE;
      end
      ST_STORE: begin
        smp_clear = 1'b1;
        if (smp_valid) begin
          tt_d[bit_idx] = smp_vote;
          if (smp_vote != EXPECTED[bit_idx]) begin
            mcnt_d = mcnt_q + 5'd1;
            if (mcnt_q == 5'd0) first_d = row_q;
          end
        end
        if (row_q == ROW_W'(ROWS - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          match_d = (tt_d == EXPECTED);
        end else begin
          row_d   = row_q + 1'b1;
          state_d = ROW_ENTRY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      row_q    <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tt_q     <= '0;
      match_q  <= 1'b0;
      mcnt_q   <= '0;
      first_q  <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      settle_q <= settle_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tt_q     <= tt_d;
      match_q  <= match_d;
      mcnt_q   <= mcnt_d;
      first_q  <= first_d;
    end
  end

  assign {in1, in2, in3, in4} = row_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign tt            = tt_q;
  assign match         = match_q;
  assign mismatch_cnt  = mcnt_q;
  assign first_bad_row = first_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Scoreboard bench: two checker instances (default timing and 0-settle/1-sample)
// driven by a golden model of the 0x5215 netlist with optional corruptions.
module tb_tt_sweep_checker;

  typedef struct {
    logic [15:0] tt;
    logic        match;
    logic [4:0]  cnt;
    logic [3:0]  fbr;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, dout_a, in1_a, in2_a, in3_a, in4_a, busy_a, done_a, match_a;
  logic [15:0] tt_a;
  logic [4:0]  mcnt_a;
  logic [3:0]  fbr_a, row_a;
  logic        rst_b, start_b, dout_b, in1_b, in2_b, in3_b, in4_b, busy_b, done_b, match_b;
  logic [15:0] tt_b;
  logic [4:0]  mcnt_b;
  logic [3:0]  fbr_b, row_b;

  int   mode_a = 0;
  logic arm_a = 1'b0, arm_b = 1'b0;
  int   cyc_a = 0, cyc_b = 0;
  int   total = 0, bad = 0;
  exp_t q_a[$], q_b[$];

  tt_sweep_checker u_dut_a (
    .clk(clk), .rst_n(rst_a), .start(start_a), .dut_out(dout_a),
    .in1(in1_a), .in2(in2_a), .in3(in3_a), .in4(in4_a),
    .busy(busy_a), .done(done_a), .tt(tt_a), .match(match_a),
    .mismatch_cnt(mcnt_a), .first_bad_row(fbr_a)
  );

  tt_sweep_checker #(.SETTLE_CYCLES(0), .SAMPLES(1), .EXPECTED(16'h5215)) u_dut_b (
    .clk(clk), .rst_n(rst_b), .start(start_b), .dut_out(dout_b),
    .in1(in1_b), .in2(in2_b), .in3(in3_b), .in4(in4_b),
    .busy(busy_b), .done(done_b), .tt(tt_b), .match(match_b),
    .mismatch_cnt(mcnt_b), .first_bad_row(fbr_b)
  );

  assign row_a = {in1_a, in2_a, in3_a, in4_a};
  assign row_b = {in1_b, in2_b, in3_b, in4_b};

  function automatic logic golden(input logic [3:0] r);
    logic i1, i2, i3, i4;
    {i1, i2, i3, i4} = r;
    return !((i1 ^ i2) & !i3) & ((i2 & !i1) ^ i4);
  endfunction

  // Cycles since start acceptance; row r occupies cycles 8r..8r+7 on instance A.
  always @(posedge clk) cyc_a <= arm_a ? 0 : cyc_a + 1;
  always @(posedge clk) cyc_b <= arm_b ? 0 : cyc_b + 1;

  always_comb begin
    dout_a = golden(row_a);
    case (mode_a)
      1: dout_a = 1'b0;
      2: dout_a = golden(row_a) ^ (row_a == 4'd6);
      3: dout_a = golden(row_a) ^ (cyc_a % 8 == 5);
      4: dout_a = golden(row_a) ^ ((cyc_a / 8 == 1) && (cyc_a % 8 == 5 || cyc_a % 8 == 6));
      default: dout_a = golden(row_a);
    endcase
  end
  assign dout_b = golden(row_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: pops the scoreboard whenever a done pulse is presented.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_a && done_a) begin
        if (q_a.size() == 0) chk("a_unexpected_done", 32'(done_a), 32'd0);
        else begin
          e = q_a.pop_front();
          chk("a_tt",    32'(tt_a),    32'(e.tt));
          chk("a_match", 32'(match_a), 32'(e.match));
          chk("a_mcnt",  32'(mcnt_a),  32'(e.cnt));
          chk("a_fbr",   32'(fbr_a),   32'(e.fbr));
          chk("a_lat",   cyc_a,        e.lat);
          chk("a_busy_at_done", 32'(busy_a), 32'd0);
        end
      end
      if (rst_b && done_b) begin
        if (q_b.size() == 0) chk("b_unexpected_done", 32'(done_b), 32'd0);
        else begin
          e = q_b.pop_front();
          chk("b_tt",    32'(tt_b),    32'(e.tt));
          chk("b_match", 32'(match_b), 32'(e.match));
          chk("b_mcnt",  32'(mcnt_b),  32'(e.cnt));
          chk("b_fbr",   32'(fbr_b),   32'(e.fbr));
          chk("b_lat",   cyc_b,        e.lat);
        end
      end
    end
  end

  task automatic start_a_sweep(input bit push, input exp_t e);
    @(negedge clk);
    start_a = 1'b1;
    arm_a   = 1'b1;
    if (push) q_a.push_back(e);
    @(negedge clk);
    start_a = 1'b0;
    arm_a   = 1'b0;
  endtask

  task automatic wait_a();
    for (int i = 0; i < 300 && q_a.size() != 0; i++) @(negedge clk);
    if (q_a.size() != 0) begin
      chk("a_timeout", 32'(q_a.size()), 32'd0);
      q_a.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_a(input int mode, input logic [15:0] t, input logic m,
                       input logic [4:0] c, input logic [3:0] f);
    exp_t e;
    e = '{tt: t, match: m, cnt: c, fbr: f, lat: 128};
    mode_a = mode;
    start_a_sweep(1'b1, e);
    wait_a();
  endtask

  initial begin
    exp_t e;
    rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tt",    32'(tt_a),    32'd0);
    chk("rst_busy",  32'(busy_a),  32'd0);
    chk("rst_done",  32'(done_a),  32'd0);
    chk("rst_match", 32'(match_a), 32'd0);
    chk("rst_mcnt",  32'(mcnt_a),  32'd0);
    chk("rst_fbr",   32'(fbr_a),   32'd0);
    chk("rst_row",   32'(row_a),   32'd0);
    rst_a = 1'b1; rst_b = 1'b1;

    // Golden sweep, with a mid-sweep busy check and post-done hold checks.
    mode_a = 0;
    e = '{tt: 16'h5215, match: 1'b1, cnt: 5'd0, fbr: 4'd0, lat: 128};
    start_a_sweep(1'b1, e);
    repeat (20) @(negedge clk);
    chk("a_busy_mid", 32'(busy_a), 32'd1);
    wait_a();
    chk("a_row_after_done",   32'(row_a),   32'hF);
    chk("a_busy_after_done",  32'(busy_a),  32'd0);
    chk("a_match_held",       32'(match_a), 32'd1);

    run_a(1, 16'h0000, 1'b0, 5'd6, 4'd1);
    run_a(2, 16'h5015, 1'b0, 5'd1, 4'd6);
    run_a(3, 16'h5215, 1'b1, 5'd0, 4'd0);
    run_a(4, 16'h1215, 1'b0, 5'd1, 4'd1);

    // Fast instance: a second start at cycle 10 must be ignored.
    @(negedge clk);
    start_b = 1'b1; arm_b = 1'b1;
    q_b.push_back('{tt: 16'h5215, match: 1'b1, cnt: 5'd0, fbr: 4'd0, lat: 32});
    @(negedge clk);
    start_b = 1'b0; arm_b = 1'b0;
    for (int i = 0; i < 50 && cyc_b != 9; i++) @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < 100 && q_b.size() != 0; i++) @(negedge clk);
    if (q_b.size() != 0) begin
      chk("b_timeout", 32'(q_b.size()), 32'd0);
      q_b.delete();
    end

    // Asynchronous reset at cycle 50 aborts the sweep with no done pulse.
    mode_a = 0;
    start_a_sweep(1'b0, e);
    for (int i = 0; i < 100 && cyc_a != 50; i++) @(negedge clk);
    #1 rst_a = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_tt",   32'(tt_a),   32'd0);
    chk("abort_row",  32'(row_a),  32'd0);
    chk("abort_mcnt", 32'(mcnt_a), 32'd0);
    chk("abort_done", 32'(done_a), 32'd0);
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    repeat (150) @(negedge clk);
    run_a(0, 16'h5215, 1'b1, 5'd0, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
